// File: rtl/riscv_pkg.sv
// Shared decode constants, operand-fetch state encoding and scoreboard width.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int REGW  = 5;
    localparam int NREGS = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        ISSUE = 2'd2
    } of_state_e;

    typedef logic [NREGS-1:0] busy_vec_t;

    // rs1 is read by everything except the upper-immediate and jump forms
    function automatic logic uses_rs1(input logic [6:0] opcode);
        return !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    endfunction

    // rs2 is read only by register-register ALU ops, stores and branches
    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_OP || opcode == OP_STORE || opcode == OP_BRANCH);
    endfunction

    // stores and branches have no destination; writes to x0 are discarded
    function automatic logic writes_rd(input logic [6:0] opcode, input logic [REGW-1:0] rd);
        return !(opcode == OP_STORE || opcode == OP_BRANCH) && (rd != '0);
    endfunction

endpackage

// File: rtl/sb_busy.sv
// Register busy scoreboard: one pending-write bit per architectural register.
// Bit 0 is tied low because x0 is never written. A set and a clear on the
// same register in one cycle leaves the bit set (the newer writer wins).
module sb_busy
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en_i,
    input  logic [REGW-1:0] set_addr_i,
    input  logic            clr_en_i,
    input  logic [REGW-1:0] clr_addr_i,
    input  logic [REGW-1:0] q1_addr_i,
    input  logic [REGW-1:0] q2_addr_i,
    output logic            q1_busy_o,
    output logic            q2_busy_o
);

    busy_vec_t busy_q;
    busy_vec_t busy_d;

    assign busy_d[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_bit
            assign busy_d[gi] = (set_en_i && set_addr_i == REGW'(gi)) ? 1'b1 :
                                (clr_en_i && clr_addr_i == REGW'(gi)) ? 1'b0 :
                                busy_q[gi];
        end
    endgenerate

    // scoreboard register, cleared on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign q1_busy_o = busy_q[q1_addr_i];
    assign q2_busy_o = busy_q[q2_addr_i];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch / issue stage with a busy-bit scoreboard for RAW hazards.
// Optional: define OPERAND_FETCH_FWD_EN to bypass same-cycle writeback data
// into a waiting operand (zero extra stall after writeback).
module operand_fetch
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic [REGW-1:0] rs1_addr,
    output logic [REGW-1:0] rs2_addr,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            wb_valid,
    input  logic [REGW-1:0] wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [REGW-1:0] out_rd_addr,
    output logic            out_rd_w
);

    of_state_e       state_q, state_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] op1_q, op1_d;
    logic [XLEN-1:0] op2_q, op2_d;

    logic            accept_ok, accept, issue_fire, held_wr;
    logic [XLEN-1:0] cand;
    logic            use1, use2, q1_busy, q2_busy;
    logic            set_hit1, set_hit2, fwd1, fwd2, hz1, hz2, hazard;
    logic [XLEN-1:0] val1, val2;

    assign accept_ok  = !rst && !flush &&
                        (state_q == IDLE || (state_q == ISSUE && out_ready));
    assign accept     = in_valid && accept_ok;
    assign issue_fire = !rst && !flush && state_q == ISSUE && out_ready;
    assign held_wr    = writes_rd(instr_q[6:0], instr_q[11:7]);

    // The instruction whose sources are being evaluated this cycle
    assign cand     = accept_ok ? in_instr : instr_q;
    assign rs1_addr = cand[19:15];
    assign rs2_addr = cand[24:20];
    assign use1     = uses_rs1(cand[6:0]);
    assign use2     = uses_rs2(cand[6:0]);

    // The instruction leaving this cycle has not reached the scoreboard yet
    assign set_hit1 = issue_fire && held_wr && instr_q[11:7] == rs1_addr;
    assign set_hit2 = issue_fire && held_wr && instr_q[11:7] == rs2_addr;

`ifdef OPERAND_FETCH_FWD_EN
    assign fwd1 = wb_valid && wb_addr == rs1_addr && rs1_addr != '0;
    assign fwd2 = wb_valid && wb_addr == rs2_addr && rs2_addr != '0;
`else
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data;
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    assign hz1    = use1 && rs1_addr != '0 && (set_hit1 || (q1_busy && !fwd1));
    assign hz2    = use2 && rs2_addr != '0 && (set_hit2 || (q2_busy && !fwd2));
    assign hazard = hz1 || hz2;

    assign val1 = !use1 ? '0 : (fwd1 ? wb_data : rs1);
    assign val2 = !use2 ? '0 : (fwd2 ? wb_data : rs2);

    sb_busy u_sb (
        .clk        (clk),
        .rst        (rst),
        .set_en_i   (issue_fire && held_wr),
        .set_addr_i (instr_q[11:7]),
        .clr_en_i   (wb_valid),
        .clr_addr_i (wb_addr),
        .q1_addr_i  (rs1_addr),
        .q2_addr_i  (rs2_addr),
        .q1_busy_o  (q1_busy),
        .q2_busy_o  (q2_busy)
    );

    // Next-state: accept, stall until sources are free, issue, or drop on flush
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        if (flush) begin
            state_d = IDLE;
        end else if (accept) begin
            instr_d = in_instr;
            pc_d    = in_pc;
            if (hazard) begin
                state_d = STALL;
            end else begin
                state_d = ISSUE;
                op1_d   = val1;
                op2_d   = val2;
            end
        end else if (state_q == STALL && !hazard) begin
            state_d = ISSUE;
            op1_d   = val1;
            op2_d   = val2;
        end else if (state_q == ISSUE && out_ready) begin
            state_d = IDLE;
        end
    end

    // Stage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            instr_q <= '0;
            pc_q    <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
        end
    end

    assign in_ready    = accept_ok;
    assign out_valid   = !rst && state_q == ISSUE;
    assign out_instr   = rst ? '0 : instr_q;
    assign out_pc      = rst ? '0 : pc_q;
    assign out_op1     = rst ? '0 : op1_q;
    assign out_op2     = rst ? '0 : op2_q;
    assign out_rd_addr = rst ? '0 : instr_q[11:7];
    assign out_rd_w    = !rst && held_wr;

endmodule
